// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Runs the inhibit/request handshake and shifts a command byte out on device clocks.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        START,
        SEND,
        RELEASE_WAIT
    } state_t;

    state_t         state_q;
    logic [2:0]     clk_sync_q;
    logic [1:0]     data_sync_q;
    logic [9:0]     frame_q;
    logic [3:0]     bit_cnt_q;
    logic [IW-1:0]  inh_cnt_q;
    logic [TW-1:0]  tout_cnt_q;
    logic           ack_ok_q;
    logic           clk_oe_q;
    logic           data_oe_q;
    logic           busy_q;
    logic           done_q;
    logic           error_q;
    logic           clk_fall;

    // [1] is the current synchronized sample, [2] the previous one.
    assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            tout_cnt_q  <= '0;
            ack_ok_q    <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            done_q      <= 1'b0;
            error_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (tx_start) begin
                        frame_q    <= {1'b1, ~^tx_data, tx_data};
                        bit_cnt_q  <= '0;
                        inh_cnt_q  <= '0;
                        tout_cnt_q <= '0;
                        ack_ok_q   <= 1'b0;
                        clk_oe_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                        data_oe_q <= 1'b1;
                        state_q   <= REQ;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + IW'(1);
                    end
                end

                REQ: begin
                    clk_oe_q   <= 1'b0;
                    tout_cnt_q <= '0;
                    state_q    <= START;
                end

                START, SEND, RELEASE_WAIT: begin
                    if (tout_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        tout_cnt_q <= tout_cnt_q + TW'(1);
                        if (state_q == START) begin
                            if (clk_fall) begin
                                data_oe_q <= ~frame_q[0];
                                bit_cnt_q <= '0;
                                state_q   <= SEND;
                            end
                        end else if (state_q == SEND) begin
                            if (clk_fall) begin
                                // Edge after the stop bit is the device ACK slot.
                                if (bit_cnt_q == 4'd9) begin
                                    ack_ok_q  <= ~data_sync_q[1];
                                    data_oe_q <= 1'b0;
                                    state_q   <= RELEASE_WAIT;
                                end else begin
                                    frame_q   <= {1'b0, frame_q[9:1]};
                                    data_oe_q <= ~frame_q[1];
                                    bit_cnt_q <= bit_cnt_q + 4'd1;
                                end
                            end
                        end else if (clk_sync_q[1] && data_sync_q[1]) begin
                            busy_q  <= 1'b0;
                            done_q  <= ack_ok_q;
                            error_q <= ~ack_ok_q;
                            state_q <= IDLE;
                        end
                    end
                end

                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 5000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (clk_line),
        .ps2_data   (data_line),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Pulse and clock-inhibit monitor, sampled 1 time unit after the active edge.
    int done_cnt = 0, err_cnt = 0, bad = 0, run = 0, last_run = 0;
    logic prev_busy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (ps2_clk_oe === 1'b1) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (tx_done === 1'b1) done_cnt++;
        if (tx_error === 1'b1) err_cnt++;
        if (tx_done === 1'b1 && tx_error === 1'b1) bad++;
        if ((tx_done === 1'b1 || tx_error === 1'b1) && tx_busy !== 1'b0) bad++;
        if (reset && prev_busy && tx_busy === 1'b0 && tx_done !== 1'b1 && tx_error !== 1'b1) bad++;
        prev_busy = (tx_busy === 1'b1);
    end

    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0), b};
    endfunction

    // Device model: waits for the host request, clocks 11 falls, samples on rising edges.
    logic [9:0] dev_bits;
    logic       dev_start;
    bit         dev_ok;
    int         dev_fall_cnt = 0;

    task automatic dev_xfer(input bit do_ack);
        int n;
        dev_ok = 1'b1;
        dev_bits = '0;
        dev_start = 1'b1;
        n = 0;
        while (clk_line && n < 2000) begin @(negedge clk); n++; end
        if (clk_line) begin dev_ok = 1'b0; return; end
        n = 0;
        while (!(clk_line && !data_line) && n < 2000) begin @(negedge clk); n++; end
        if (!(clk_line && !data_line)) begin dev_ok = 1'b0; return; end
        repeat (10) @(negedge clk);
        dev_start = data_line;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            dev_fall_cnt = k;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            @(negedge clk);
            if (k <= 10) dev_bits[k-1] = data_line;
            if (k == 10) dev_data_low = do_ack;
            repeat (19) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data = 8'($urandom);
        chk("busy_after_start", {31'd0, tx_busy}, 1);
        chk("clk_oe_after_start", {31'd0, ps2_clk_oe}, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        chk("idle_reached", {31'd0, tx_busy}, 0);
    endtask

    task automatic run_xfer(input logic [7:0] b, input bit ack);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        dev_fall_cnt = 0;
        start_tx(b);
        dev_xfer(ack);
        wait_idle();
        chk("dev_handshake", {31'd0, dev_ok}, 1);
        chk("start_bit", {31'd0, dev_start}, 0);
        chk("frame_bits", {22'd0, dev_bits}, {22'd0, exp_frame(b)});
        chk("inhibit_len", last_run, INH + 1);
        chk("done_pulses", done_cnt - d0, ack ? 1 : 0);
        chk("error_pulses", err_cnt - e0, ack ? 0 : 1);
    endtask

    initial begin
        int d0, e0, n;

        reset = 1'b0;
        tx_start = 1'b1;
        tx_data = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 0);
        end
        tx_start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        run_xfer(8'hED, 1'b1);
        run_xfer(8'hF4, 1'b1);
        for (int i = 0; i < 3; i++) run_xfer(8'($urandom), 1'b1);
        run_xfer(8'($urandom), 1'b0);

        // Device never clocks: timeout measured from START entry.
        e0 = err_cnt;
        d0 = done_cnt;
        start_tx(8'h55);
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (tx_error !== 1'b1 && n < TMO + 1000) begin @(negedge clk); n++; end
        chk("timeout_cycles", n, TMO);
        chk("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        chk("timeout_busy", {31'd0, tx_busy}, 0);
        @(negedge clk);
        chk("timeout_err_cnt", err_cnt - e0, 1);
        chk("timeout_done_cnt", done_cnt - d0, 0);

        // Start request while busy must be ignored.
        d0 = done_cnt;
        dev_fall_cnt = 0;
        start_tx(8'hFF);
        fork
            dev_xfer(1'b1);
            begin
                int m = 0;
                while (dev_fall_cnt < 3 && m < 2000) begin @(negedge clk); m++; end
                tx_start = 1'b1;
                tx_data = 8'h00;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_idle();
        chk("busy_start_frame", {22'd0, dev_bits}, {22'd0, exp_frame(8'hFF)});
        chk("busy_start_done", done_cnt - d0, 1);
        repeat (30) @(negedge clk);
        chk("busy_start_no_retx", {30'd0, ps2_clk_oe, tx_busy}, 0);

        // Reset while data bit 4 is on the line.
        d0 = done_cnt;
        e0 = err_cnt;
        dev_fall_cnt = 0;
        start_tx(8'hA5);
        fork
            dev_xfer(1'b1);
            begin
                int m = 0;
                while (dev_fall_cnt < 5 && m < 2000) begin @(negedge clk); m++; end
                repeat (5) @(negedge clk);
                chk("bit4_drive", {31'd0, ps2_data_oe}, 1);
                reset = 1'b0;
                @(negedge clk);
                chk("midreset_lines", {29'd0, ps2_clk_oe, ps2_data_oe, tx_busy}, 0);
                reset = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        chk("midreset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        chk("pulse_rules", bad, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
